// File: rtl/std_fp_div_pkg.sv
// std_fp_div_pkg: shared types and helpers for the iterative fixed-point divider.
//   state_t   : divider FSM states (IDLE/RUN/FIX/DONE)
//   sat_const : saturation constant for a given result width and sign
package std_fp_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned SAT_MAXW = 64;

  // Low `width` bits hold the constant: all ones for unsigned results,
  // 0x7F..F for a positive signed result, 0x80..0 for a negative one.
  function automatic logic [SAT_MAXW-1:0] sat_const(input int unsigned width,
                                                    input logic        is_signed,
                                                    input logic        neg);
    logic [SAT_MAXW-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < SAT_MAXW; i++) begin
      if (!is_signed)  v[i] = (i < width);
      else if (neg)    v[i] = (i == width - 1);
      else             v[i] = (i < width - 1);
    end
    return v;
  endfunction

endpackage

// File: rtl/std_fp_div_step.sv
// std_fp_div_step: one combinational restoring-division step.
//   i_acc     : partial remainder (always < divisor, so WIDTH bits suffice)
//   i_bit     : next dividend bit, shifted in at the LSB
//   i_divisor : divisor magnitude
//   o_acc     : next partial remainder
//   o_q       : resolved quotient bit
module std_fp_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_q
);

  // The shifted value needs WIDTH+1 bits; after the conditional subtract it
  // is below the divisor again and fits back into WIDTH bits.
  logic [WIDTH:0]   w_sh;
  logic [WIDTH-1:0] w_diff;

  assign w_sh   = {i_acc, i_bit};
  assign w_diff = w_sh[WIDTH-1:0] - i_divisor;
  assign o_q    = (w_sh >= {1'b0, i_divisor});
  assign o_acc  = o_q ? w_diff : w_sh[WIDTH-1:0];

endmodule

// File: rtl/std_fp_div_iter.sv
// std_fp_div_iter: iterative fixed-point divider behind a go/done handshake.
// quotient = (left * 2^FRAC_WIDTH) / right, unsigned or signed (truncating
// toward zero), BITS_PER_CYCLE quotient bits per RUN cycle.
// Ports:
//   clk, reset_n (async, active-low)
//   go            : start request, sampled in IDLE only
//   left, right   : dividend / divisor
//   out_quotient  : quotient, same fixed-point format as the operands
//   out_remainder : remainder (takes the dividend's sign in signed mode)
//   div_by_zero   : right was zero
//   overflow      : true quotient not representable in WIDTH bits
//   done          : one-cycle pulse, results valid and held until next FIX
// Optional macro STD_FP_DIV_SAT_EN: saturate out_quotient on overflow or
// divide-by-zero instead of wrapping / returning all ones.
module std_fp_div_iter
  import std_fp_div_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int INT_WIDTH      = 16,
  parameter int FRAC_WIDTH     = 16,
  parameter int SIGNED         = 0,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic             done
);

  localparam int ITER = WIDTH + FRAC_WIDTH;
  localparam int N    = ITER / BITS_PER_CYCLE;
  localparam int CW   = $clog2(N + 1);
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

  if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_chk_fmt
    $error("std_fp_div_iter: INT_WIDTH + FRAC_WIDTH must equal WIDTH");
  end
  if (ITER % BITS_PER_CYCLE != 0) begin : g_chk_bpc
    $error("std_fp_div_iter: WIDTH + FRAC_WIDTH must be a multiple of BITS_PER_CYCLE");
  end

  state_t          r_state;
  logic [ITER-1:0] r_dvd;
  logic [ITER-1:0] r_quo;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_left;
  logic            r_sl, r_sr, r_dz;
  logic [CW-1:0]   r_cnt;

  // Restoring step chain, MSB of the dividend first.
  logic [WIDTH-1:0]          w_acc [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] w_qb;

  assign w_acc[0] = r_acc;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    std_fp_div_step #(.WIDTH(WIDTH)) u_step (
      .i_acc     (w_acc[g]),
      .i_bit     (r_dvd[ITER-1-g]),
      .i_divisor (r_div),
      .o_acc     (w_acc[g+1]),
      .o_q       (w_qb[BITS_PER_CYCLE-1-g])
    );
  end

  // Operand magnitudes at acceptance; -(-2^(W-1)) wraps to 2^(W-1) unsigned.
  logic             w_l_neg, w_r_neg;
  logic [WIDTH-1:0] w_lmag, w_rmag;

  always_comb begin
    w_l_neg = (SIGNED != 0) && left[WIDTH-1];
    w_r_neg = (SIGNED != 0) && right[WIDTH-1];
    w_lmag  = w_l_neg ? -left  : left;
    w_rmag  = w_r_neg ? -right : right;
  end

  // Result formatting for the FIX cycle.
  logic             w_neg, w_ovf;
  logic [WIDTH-1:0] w_qlow, w_q, w_rem;

  always_comb begin
    w_qlow = r_quo[WIDTH-1:0];
    w_neg  = (SIGNED != 0) && (r_sl ^ r_sr);
    w_ovf  = |r_quo[ITER-1:WIDTH];
    if (SIGNED != 0) begin
      if (w_neg) w_ovf = w_ovf | (w_qlow > HALF);
      else       w_ovf = w_ovf | w_qlow[WIDTH-1];
    end
    w_rem = ((SIGNED != 0) && r_sl) ? -r_acc : r_acc;
`ifdef STD_FP_DIV_SAT_EN
    if (r_dz)       w_q = WIDTH'(sat_const(WIDTH, SIGNED != 0, r_sl));
    else if (w_ovf) w_q = WIDTH'(sat_const(WIDTH, SIGNED != 0, w_neg));
    else            w_q = w_neg ? -w_qlow : w_qlow;
`else
    if (r_dz) w_q = '1;
    else      w_q = w_neg ? -w_qlow : w_qlow;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_dvd         <= '0;
      r_quo         <= '0;
      r_acc         <= '0;
      r_div         <= '0;
      r_left        <= '0;
      r_sl          <= 1'b0;
      r_sr          <= 1'b0;
      r_dz          <= 1'b0;
      r_cnt         <= '0;
      out_quotient  <= '0;
      out_remainder <= '0;
      div_by_zero   <= 1'b0;
      overflow      <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (go) begin
            r_dvd   <= {w_lmag, {FRAC_WIDTH{1'b0}}};
            r_div   <= w_rmag;
            r_left  <= left;
            r_sl    <= w_l_neg;
            r_sr    <= w_r_neg;
            r_dz    <= (right == '0);
            r_acc   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc <= w_acc[BITS_PER_CYCLE];
          r_dvd <= r_dvd << BITS_PER_CYCLE;
          r_quo <= (r_quo << BITS_PER_CYCLE) | ITER'(w_qb);
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(N - 1)) r_state <= FIX;
        end
        FIX: begin
          out_quotient  <= w_q;
          out_remainder <= r_dz ? r_left : w_rem;
          div_by_zero   <= r_dz;
          overflow      <= r_dz ? 1'b0 : w_ovf;
          done          <= 1'b1;
          r_state       <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_std_fp_div_iter.sv
// tb_std_fp_div_iter: directed checks of std_fp_div_iter in Q4.4 format.
// u0: unsigned, 1 bit/cycle; u1: unsigned, 2 bits/cycle; u2: signed, 1 bit/cycle.
module tb_std_fp_div_iter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       go  [3];
  logic [7:0] lft [3];
  logic [7:0] rgt [3];
  logic [7:0] q   [3];
  logic [7:0] rem [3];
  logic       dz  [3];
  logic       ovf [3];
  logic       done[3];

  int checks   = 0;
  int failures = 0;

`ifdef STD_FP_DIV_SAT_EN
  localparam logic [7:0] E_OVF_Q = 8'hFF;
  localparam logic [7:0] E_DZ_P  = 8'h7F;
  localparam logic [7:0] E_DZ_N  = 8'h80;
`else
  localparam logic [7:0] E_OVF_Q = 8'h00;
  localparam logic [7:0] E_DZ_P  = 8'hFF;
  localparam logic [7:0] E_DZ_N  = 8'hFF;
`endif

  std_fp_div_iter #(.WIDTH(8), .INT_WIDTH(4), .FRAC_WIDTH(4), .SIGNED(0), .BITS_PER_CYCLE(1)) u0 (
    .clk(clk), .reset_n(reset_n), .go(go[0]), .left(lft[0]), .right(rgt[0]),
    .out_quotient(q[0]), .out_remainder(rem[0]), .div_by_zero(dz[0]),
    .overflow(ovf[0]), .done(done[0]));

  std_fp_div_iter #(.WIDTH(8), .INT_WIDTH(4), .FRAC_WIDTH(4), .SIGNED(0), .BITS_PER_CYCLE(2)) u1 (
    .clk(clk), .reset_n(reset_n), .go(go[1]), .left(lft[1]), .right(rgt[1]),
    .out_quotient(q[1]), .out_remainder(rem[1]), .div_by_zero(dz[1]),
    .overflow(ovf[1]), .done(done[1]));

  std_fp_div_iter #(.WIDTH(8), .INT_WIDTH(4), .FRAC_WIDTH(4), .SIGNED(1), .BITS_PER_CYCLE(1)) u2 (
    .clk(clk), .reset_n(reset_n), .go(go[2]), .left(lft[2]), .right(rgt[2]),
    .out_quotient(q[2]), .out_remainder(rem[2]), .div_by_zero(dz[2]),
    .overflow(ovf[2]), .done(done[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation, measure edges from the go edge to done, check results.
  // With scramble set, the operands are changed while the divider is running.
  task automatic run(input int sel, input logic [7:0] l, input logic [7:0] r,
                     input int n, input bit scramble,
                     input logic [7:0] eq, input logic [7:0] erem,
                     input logic edz, input logic eovf, input string tag);
    int lat;
    @(negedge clk);
    go[sel] = 1'b1; lft[sel] = l; rgt[sel] = r;
    @(posedge clk); #1;
    go[sel] = 1'b0;
    lat = 0;
    while (!done[sel] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (scramble && lat == 3) begin
        lft[sel] = ~l;
        rgt[sel] = 8'h01;
      end
    end
    check({tag, ".lat"}, lat, n + 1);
    check({tag, ".q"},   q[sel],   eq);
    check({tag, ".rem"}, rem[sel], erem);
    check({tag, ".dz"},  dz[sel],  edz);
    check({tag, ".ovf"}, ovf[sel], eovf);
    @(posedge clk); #1;
    check({tag, ".pulse"}, done[sel], 1'b0);
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < 3; i++) begin
      go[i] = 1'b0; lft[i] = '0; rgt[i] = '0;
    end
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.q",    q[0],    8'h00);
    check("rst.rem",  rem[0],  8'h00);
    check("rst.done", done[0], 1'b0);
    check("rst.dz",   dz[2],   1'b0);
    check("rst.ovf",  ovf[2],  1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // 3.0/2.0 = 1.5 ; 1.0/3.0 = 0x05 rem 0x10
    run(0, 8'h30, 8'h20, 12, 1'b0, 8'h18, 8'h00, 1'b0, 1'b0, "u_a");
    run(0, 8'h10, 8'h30, 12, 1'b0, 8'h05, 8'h10, 1'b0, 1'b0, "u_b");
    run(1, 8'h10, 8'h30,  6, 1'b0, 8'h05, 8'h10, 1'b0, 1'b0, "b2_b");
    run(1, 8'h30, 8'h20,  6, 1'b0, 8'h18, 8'h00, 1'b0, 1'b0, "b2_a");
    // signed: -3.0/2.0 = -1.5 ; -1.0/3.0 = -5 lsb, remainder -0x10
    run(2, 8'hD0, 8'h20, 12, 1'b0, 8'hE8, 8'h00, 1'b0, 1'b0, "s_a");
    run(2, 8'hF0, 8'h30, 12, 1'b0, 8'hFB, 8'hF0, 1'b0, 1'b0, "s_b");
    // divide by zero, fixed latency
    run(2, 8'h30, 8'h00, 12, 1'b0, E_DZ_P, 8'h30, 1'b1, 1'b0, "dz_p");
    run(2, 8'hD0, 8'h00, 12, 1'b0, E_DZ_N, 8'hD0, 1'b1, 1'b0, "dz_n");
    run(0, 8'h55, 8'h00, 12, 1'b0, 8'hFF,  8'h55, 1'b1, 1'b0, "dz_u");
    // 15.0/(1/16) = 0xF00, does not fit
    run(0, 8'hF0, 8'h01, 12, 1'b0, E_OVF_Q, 8'h00, 1'b0, 1'b1, "ovf");
    // operands scrambled mid-RUN
    run(0, 8'h30, 8'h20, 12, 1'b1, 8'h18, 8'h00, 1'b0, 1'b0, "scr");

    // reset during RUN cycle 5: immediate clear, no done
    @(negedge clk);
    go[0] = 1'b1; lft[0] = 8'h30; rgt[0] = 8'h20;
    @(posedge clk); #1;
    go[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_mid.q",    q[0],    8'h00);
    check("rst_mid.rem",  rem[0],  8'h00);
    check("rst_mid.done", done[0], 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done[0]) pulses++;
    end
    check("rst_mid.nodone", pulses, 0);
    run(0, 8'h10, 8'h30, 12, 1'b0, 8'h05, 8'h10, 1'b0, 1'b0, "post_rst");

    // go held through the whole operation up to the return to IDLE
    @(negedge clk);
    go[0] = 1'b1; lft[0] = 8'h30; rgt[0] = 8'h20;
    pulses = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done[0]) pulses++;
    end
    go[0] = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done[0]) pulses++;
    end
    check("go_held.pulses", pulses, 1);
    check("go_held.q", q[0], 8'h18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/std_fp_div_iter.md
Name: std_fp_div_iter

Overview:
Parametrised iterative fixed-point divider; the successor to the single-mode unsigned sequential fixed-point divider in the fixed-point primitive library.
- Computes quotient = (left * 2^FRAC_WIDTH) / right and the matching remainder, in unsigned or signed (truncate-toward-zero) mode.
- Retires BITS_PER_CYCLE quotient bits per cycle.
- Flags divide-by-zero and quotient overflow.
- Sits behind the Calyx go/done handshake, like the other pipelined fixed-point primitives.

Parameters:
WIDTH, 32, operand/result width
INT_WIDTH, 16, integer bits; must satisfy INT_WIDTH + FRAC_WIDTH == WIDTH, else $error at elaboration
FRAC_WIDTH, 16, fraction bits
SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands
BITS_PER_CYCLE, 1, quotient bits resolved per cycle; (WIDTH+FRAC_WIDTH) % BITS_PER_CYCLE must be 0, else $error

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
go  input  1  start request; sampled only in IDLE
left  input  WIDTH  dividend
right  input  WIDTH  divisor
out_quotient  output  WIDTH  quotient, fixed-point, same format as operands
out_remainder  output  WIDTH  remainder of (left*2^FRAC_WIDTH) / right
div_by_zero  output  1  right was 0 for the current result
overflow  output  1  true quotient not representable in WIDTH bits
done  output  1  one-cycle pulse; results valid

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low. While reset_n is low: state = IDLE; all outputs = 0; internal accumulator, quotient and counter = 0.
- Reset mid-operation: aborts immediately; no done is produced.
- Definitions: ITER = WIDTH + FRAC_WIDTH; N = ITER / BITS_PER_CYCLE.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE: on go=1, latch left and right, clear the counter, go to RUN.
  - SIGNED=1: latch magnitudes as WIDTH-bit unsigned (-2^(WIDTH-1) → 2^(WIDTH-1)) and record sign_l, sign_r.
  - If right == 0, set the dz flag.
  - Dividend register = {magnitude(left), FRAC_WIDTH zeros}; accumulator is WIDTH+1 bits, cleared.
- RUN: exactly N cycles. Each cycle applies BITS_PER_CYCLE chained restoring steps (MSB first):
  - acc = {acc, next dividend bit}; if acc >= divisor then subtract and shift in 1, else shift in 0.
  - Counter increments; leaving RUN after count N-1.
- Divide-by-zero: RUN still runs all N cycles, so latency is constant.
- FIX: one cycle; registers the outputs.
  - Raw quotient is ITER bits. overflow = any raw bit above WIDTH-1 is set, or (SIGNED and the magnitude exceeds the signed range for the result sign).
  - Result quotient = low WIDTH bits, negated if SIGNED and sign_l^sign_r.
  - Remainder = final acc[WIDTH-1:0], negated if SIGNED and sign_l (takes the dividend's sign).
  - Divide-by-zero: out_quotient = all ones, out_remainder = left as latched (raw), div_by_zero = 1, overflow = 0.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. Outputs hold their values until the next FIX.
- Latency: go sampled at edge k → done high in the cycle after edge k+N+1 (N+2 edges). A new go can be accepted in the IDLE cycle after DONE.
- go in RUN/FIX/DONE is ignored. Operand changes after acceptance are ignored.

Optional Feature:
STD_FP_DIV_SAT_EN:
- Defined: overflow or divide-by-zero saturates out_quotient.
  - Unsigned: all ones.
  - Signed: 0x7F..F if the result is positive, 0x80..0 if negative. For divide-by-zero, the sign is that of left.
  - Flags are unchanged.
- Undefined: quotient wraps (low WIDTH bits) on overflow; all ones on divide-by-zero, per Behaviour.

Decomposition:
- Package std_fp_div_pkg: state enum typedef (IDLE/RUN/FIX/DONE); function for saturation constants by width and sign.
- Sub-module std_fp_div_step: combinational single restoring step with inputs acc, dividend bit and divisor, outputs next acc and quotient bit. Instantiated BITS_PER_CYCLE times in a generate chain.

Test Plan:
1. WIDTH=8, INT=4, FRAC=4, SIGNED=0, BPC=1; left=0x30, right=0x20 → done 14 cycles after go edge; quotient=0x18, remainder=0x00, flags 0.
2. Same config, left=0x10, right=0x30 → quotient=0x05, remainder=0x10. Repeat with BPC=2 → identical results, done after 8 cycles.
3. SIGNED=1: left=0xD0, right=0x20 → quotient=0xE8. Then left=0xF0, right=0x30 → quotient=0xFB, remainder=0xF0.
4. Divide-by-zero: SIGNED=1, left=0x30, right=0x00 → div_by_zero=1 at fixed latency.
   - SAT undefined: quotient=0xFF, remainder=0x30.
   - SAT defined: quotient=0x7F; with left=0xD0 → quotient=0x80.
5. Overflow: SIGNED=0, left=0xF0, right=0x01 → overflow=1; quotient=0x00 without SAT, 0xFF with SAT.
6. Control edge cases:
   - reset_n low at RUN cycle 5 → outputs 0 immediately, no done pulse; next go completes normally.
   - go held high across DONE → exactly one done per accepted operation.
   - Operands changed mid-RUN → result unaffected.
